// File: rtl/cnn_param_pkg.sv
// Shared definitions for the CNN parameter-load controller.
//   - default segment sizes (words per parameter buffer)
//   - FSM state encoding
//   - one-hot buffer bit positions {db,dw,cb,cw}
//   - arbiter read-enable patterns per engine
package cnn_param_pkg;

    localparam int N_CW_DEF = 288;
    localparam int N_CB_DEF = 32;
    localparam int N_DW_DEF = 288;
    localparam int N_DB_DEF = 32;

    localparam int SEG_CW = 0;
    localparam int SEG_CB = 1;
    localparam int SEG_DW = 2;
    localparam int SEG_DB = 3;

    // Conv engine reads conv weights+bias, dwconv engine reads dw weights+bias.
    localparam logic [3:0] R_EN_CONV = 4'b0011;
    localparam logic [3:0] R_EN_DW   = 4'b1100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_CW = 3'd1,
        LD_CB = 3'd2,
        LD_DW = 3'd3,
        LD_DB = 3'd4,
        READY = 3'd5
    } state_e;

    // Buffer write-enable bit for the segment being loaded; zero outside LD_*.
    function automatic logic [3:0] seg_onehot(input state_e s);
        case (s)
            LD_CW:   return 4'(1 << SEG_CW);
            LD_CB:   return 4'(1 << SEG_CB);
            LD_DW:   return 4'(1 << SEG_DW);
            LD_DB:   return 4'(1 << SEG_DB);
            default: return 4'b0000;
        endcase
    endfunction

    function automatic state_e next_seg(input state_e s);
        case (s)
            LD_CW:   return LD_CB;
            LD_CB:   return LD_DW;
            LD_DW:   return LD_DB;
            LD_DB:   return READY;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter for the parameter buffers.
// Ports:
//   clk, rst_n   clock / async active-low reset (already synchronised)
//   en           arbitration allowed (controller in READY, no restart)
//   req[1:0]     {dwconv, conv} read requests
//   gnt[1:0]     registered one-hot grant
//   r_en[3:0]    one-cycle buffer read enables at the start of a grant
module rr_arb2
    import cnn_param_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [3:0] r_en
);

    logic [1:0] gnt_q, gnt_d;
    logic [3:0] r_en_q, r_en_d;
    // 1 when the dwconv engine was granted most recently.
    logic       last_q, last_d;
    logic [1:0] pick;

    always_comb begin
        gnt_d  = gnt_q;
        r_en_d = 4'b0000;
        last_d = last_q;
        pick   = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
        if (!en) begin
            gnt_d = 2'b00;
        end else if (gnt_q == 2'b00) begin
            if (req != 2'b00) begin
                gnt_d  = pick;
                r_en_d = pick[0] ? R_EN_CONV : R_EN_DW;
                last_d = pick[1];
            end
        end else if ((gnt_q & req) == 2'b00) begin
            gnt_d = 2'b00;
        end
    end

    // last_q resets to 1 so the conv engine wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= 2'b00;
            r_en_q <= 4'b0000;
            last_q <= 1'b1;
        end else begin
            gnt_q  <= gnt_d;
            r_en_q <= r_en_d;
            last_q <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign r_en = r_en_q;

endmodule

// File: rtl/param_load_ctrl.sv
// Streams CNN parameters into four buffers (conv weights, conv bias,
// dwconv weights, dwconv bias) in fixed order, then arbitrates read access
// between the conv and dwconv engines.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   start                 begin (re)load; ignored while loading
//   s_valid/s_data/s_ready  parameter word stream
//   wr_sel/wr_addr/wr_data  buffer write port, one-hot {db,dw,cb,cw}
//   seg_done, load_done   per-segment / overall load status
//   req, gnt, r_en        read arbitration {dwconv, conv}
//
// state | meaning
// IDLE  | waiting for start after reset
// LD_CW | loading conv weights
// LD_CB | loading conv bias
// LD_DW | loading dwconv weights
// LD_DB | loading dwconv bias
// READY | all loaded, read arbitration active
module param_load_ctrl
    import cnn_param_pkg::*;
#(
    parameter int N_CW = N_CW_DEF,
    parameter int N_CB = N_CB_DEF,
    parameter int N_DW = N_DW_DEF,
    parameter int N_DB = N_DB_DEF,
    parameter int AW   = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [15:0]   s_data,
    output logic          s_ready,
    output logic [3:0]    wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [3:0]    seg_done,
    output logic          load_done,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic [3:0]    r_en
);

    // Reset asserts asynchronously, releases two edges later.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [3:0]    seg_done_q, seg_done_d;
    logic [3:0]    seg_bit;
    logic [AW-1:0] last_idx;
    logic          accept;
    logic          arb_en;

    always_comb begin
        seg_bit = seg_onehot(state_q);
        case (state_q)
            LD_CW:   last_idx = AW'(N_CW - 1);
            LD_CB:   last_idx = AW'(N_CB - 1);
            LD_DW:   last_idx = AW'(N_DW - 1);
            LD_DB:   last_idx = AW'(N_DB - 1);
            default: last_idx = '0;
        endcase
    end

    assign s_ready = (seg_bit != 4'b0000);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seg_done_d = seg_done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_CW;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (start) begin
                    state_d    = LD_CW;
                    cnt_d      = '0;
                    seg_done_d = 4'b0000;
                end
            end
            default: begin
                if (!s_ready) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (cnt_q == last_idx) begin
                        state_d    = next_seg(state_q);
                        cnt_d      = '0;
                        seg_done_d = seg_done_q | seg_bit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seg_done_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_done_q <= seg_done_d;
        end
    end

    assign wr_sel    = accept ? seg_bit : 4'b0000;
    assign wr_addr   = cnt_q;
    assign wr_data   = s_data;
    assign seg_done  = seg_done_q;
    assign load_done = (state_q == READY);

    // A restart from READY drops any grant on the same edge as the state change.
    assign arb_en = (state_q == READY) && !start;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_sync_q),
        .en    (arb_en),
        .req   (req),
        .gnt   (gnt),
        .r_en  (r_en)
    );

endmodule

// File: tb/tb_param_load_ctrl.sv
module tb_param_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [3:0]  wr_sel;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  seg_done;
    logic        load_done;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [3:0]  r_en;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  sel;
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    param_load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .seg_done  (seg_done),
        .load_done (load_done),
        .req       (req),
        .gnt       (gnt),
        .r_en      (r_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Status after n words of a 288/32/288/32 load have been accepted.
    function automatic logic [3:0] exp_seg(input int n);
        logic [3:0] s;
        s[0] = (n >= 288);
        s[1] = (n >= 320);
        s[2] = (n >= 608);
        s[3] = (n >= 640);
        return s;
    endfunction

    function automatic wr_t exp_write(input int b);
        wr_t e;
        e.data = 16'(b);
        if (b < 288) begin
            e.sel = 4'b0001; e.addr = 9'(b);
        end else if (b < 320) begin
            e.sel = 4'b0010; e.addr = 9'(b - 288);
        end else if (b < 608) begin
            e.sel = 4'b0100; e.addr = 9'(b - 320);
        end else begin
            e.sel = 4'b1000; e.addr = 9'(b - 608);
        end
        return e;
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams words 0..nbeats-1; leaves time at posedge+1 after the last beat.
    task automatic run_load(input bit do_st, input bit gaps, input int nbeats, input int req_at);
        int  b   = 0;
        int  cyc = 0;
        wr_t e;
        if (do_st) do_start();
        while (b < nbeats && cyc < 10000) begin
            cyc++;
            if (req_at >= 0 && b >= req_at) req = 2'b01;
            s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data  = 16'(b);
            if (s_valid) exp_q.push_back(exp_write(b));
            @(negedge clk);
            checks++;
            if (seg_done !== exp_seg(b)) begin
                failures++;
                $display("FAIL seg_done beat=%0d got=%b exp=%b", b, seg_done, exp_seg(b));
            end
            checks++;
            if (s_ready !== 1'b1 || load_done !== 1'b0) begin
                failures++;
                $display("FAIL load_status beat=%0d got s_ready=%b load_done=%b exp 1/0", b, s_ready, load_done);
            end
            checks++;
            if (gnt !== 2'b00) begin
                failures++;
                $display("FAIL gnt_during_load beat=%0d got=%b exp=00", b, gnt);
            end
            checks++;
            if (s_valid) begin
                if (exp_q.size() == 0 || wr_sel === 4'b0000) begin
                    failures++;
                    $display("FAIL missing_write beat=%0d got wr_sel=%b exp nonzero", b, wr_sel);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_sel, wr_addr, wr_data} !== e) begin
                        failures++;
                        $display("FAIL write beat=%0d got sel=%b addr=%0d data=%0d exp sel=%b addr=%0d data=%0d",
                                 b, wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
                    end
                end
                b++;
            end else if (wr_sel !== 4'b0000) begin
                failures++;
                $display("FAIL gap_write beat=%0d got wr_sel=%b exp=0000", b, wr_sel);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checks++;
        if (b < nbeats) begin
            failures++;
            $display("FAIL load_timeout got beats=%0d exp=%0d", b, nbeats);
        end
        if (nbeats == 640) begin
            @(negedge clk);
            checks++;
            if (seg_done !== 4'b1111 || load_done !== 1'b1 || s_ready !== 1'b0 ||
                wr_sel !== 4'b0000 || gnt !== 2'b00) begin
                failures++;
                $display("FAIL load_end got seg=%b ld=%b rdy=%b sel=%b gnt=%b exp 1111/1/0/0000/00",
                         seg_done, load_done, s_ready, wr_sel, gnt);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (s_ready !== 1'b0 || wr_sel !== 4'b0000 || wr_addr !== 9'd0 || seg_done !== 4'b0000 ||
            load_done !== 1'b0 || gnt !== 2'b00 || r_en !== 4'b0000) begin
            failures++;
            $display("FAIL %s got rdy=%b sel=%b addr=%0d seg=%b ld=%b gnt=%b ren=%b exp all 0",
                     tag, s_ready, wr_sel, wr_addr, seg_done, load_done, gnt, r_en);
        end
    endtask

    task automatic check_arb(input string tag, input logic [1:0] eg, input logic [3:0] er);
        checks++;
        if (gnt !== eg || r_en !== er) begin
            failures++;
            $display("FAIL %s got gnt=%b r_en=%b exp gnt=%b r_en=%b", tag, gnt, r_en, eg, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_load_b2b();
        run_load(1'b1, 1'b0, 640, -1);
    endtask

    task automatic test_arb_rr();
        @(posedge clk); #1;
        req = 2'b11;
        @(negedge clk); check_arb("arb_latency", 2'b00, 4'b0000);
        @(negedge clk); check_arb("arb_first_conv", 2'b01, 4'b0011);
        @(negedge clk); check_arb("arb_hold_conv", 2'b01, 4'b0000);
        @(posedge clk); #1;
        req = 2'b10;
        @(negedge clk); check_arb("arb_drop_same_cycle", 2'b01, 4'b0000);
        @(negedge clk); check_arb("arb_dropped", 2'b00, 4'b0000);
        @(negedge clk); check_arb("arb_grant_dw", 2'b10, 4'b1100);
        @(negedge clk); check_arb("arb_hold_dw", 2'b10, 4'b0000);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk); check_arb("arb_dw_release_wait", 2'b10, 4'b0000);
        @(negedge clk); check_arb("arb_dw_released", 2'b00, 4'b0000);
        @(posedge clk); #1;
        req = 2'b11;
        @(negedge clk);
        @(negedge clk); check_arb("arb_rr_conv_after_dw", 2'b01, 4'b0011);
    endtask

    task automatic test_restart_in_grant();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk); check_arb("restart_before_edge", 2'b01, 4'b0000);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_arb("restart_gnt_dropped", 2'b00, 4'b0000);
        checks++;
        if (s_ready !== 1'b1 || seg_done !== 4'b0000 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL restart_status got rdy=%b seg=%b ld=%b exp 1/0000/0", s_ready, seg_done, load_done);
        end
        @(posedge clk); #1;
        req = 2'b00;
    endtask

    task automatic test_gapped_with_req();
        run_load(1'b0, 1'b1, 640, 400);
        @(negedge clk); check_arb("req_held_grant_in_ready", 2'b01, 4'b0011);
        @(posedge clk); #1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_load();
        run_load(1'b1, 1'b0, 100, -1);
        s_valid = 1'b1;
        req     = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_load");
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        req     = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("after_reset_release");
        run_load(1'b1, 1'b0, 640, -1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'd0;
        req     = 2'b00;
        test_reset();
        test_load_b2b();
        test_arb_rr();
        test_restart_in_grant();
        test_gapped_with_req();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
